// File: rtl/pipe_if_unit.sv
// Instruction-fetch stage: PC register, instruction-memory handshake and the IF/ID
// instruction register, with stall buffering and wrong-path squashing.
module pipe_if_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] da,
  input  logic [31:0] jpc,
  input  logic        wpcir,
  input  logic        jwait,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        inst_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] dpc4_q, dpc4_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic        req_q, req_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic        redir_pend_q, redir_pend_d;

  logic [31:0] pc_plus4_s;
  logic [31:0] npc_s;
  logic        redirect_s;

  // Next-PC select; pc+4 wraps naturally at 2^32.
  always_comb begin
    pc_plus4_s = pc_q + 32'd4;
    redirect_s = (pcsource != 2'b00) && wpcir;
    case (pcsource)
      2'b00:   npc_s = pc_plus4_s;
      2'b01:   npc_s = bpc;
      2'b10:   npc_s = da;
      2'b11:   npc_s = jpc;
      default: npc_s = pc_plus4_s;
    endcase
  end

  // Fetch FSM next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    dpc4_d       = dpc4_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    req_d        = req_q;
    hold_buf_d   = hold_buf_q;
    redir_pc_d   = redir_pc_q;
    redir_pend_d = redir_pend_q;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        req_d   = 1'b1;
      end

      FETCH: begin
        if (imem_ack) begin
          if (redir_pend_q) begin
            // Word belongs to the abandoned path; a fresh redirect still wins.
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
            redir_pend_d = 1'b0;
            if (redirect_s) begin
              pc_d = npc_s;
            end else begin
              pc_d = redir_pc_q;
            end
          end else if (wpcir) begin
            pc_d   = npc_s;
            dpc4_d = pc_plus4_s;
            if (jwait) begin
              inst_d       = NOP_WORD;
              inst_valid_d = 1'b0;
            end else begin
              inst_d       = imem_rdata;
              inst_valid_d = 1'b1;
            end
          end else begin
            hold_buf_d = imem_rdata;
            state_d    = HOLD;
            req_d      = 1'b0;
          end
        end else begin
          if (wpcir) begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
            if (redirect_s) begin
              redir_pc_d   = npc_s;
              redir_pend_d = 1'b1;
            end else begin
              redir_pend_d = redir_pend_q;
            end
          end else begin
            inst_d = inst_q;
          end
        end
      end

      HOLD: begin
        if (wpcir) begin
          state_d = FETCH;
          req_d   = 1'b1;
          pc_d    = npc_s;
          dpc4_d  = pc_plus4_s;
          if (redirect_s || jwait) begin
            inst_d       = NOP_WORD;
            inst_valid_d = 1'b0;
          end else begin
            inst_d       = hold_buf_q;
            inst_valid_d = 1'b1;
          end
          if (redirect_s) begin
            hold_buf_d = 32'h0000_0000;
          end else begin
            hold_buf_d = hold_buf_q;
          end
        end else begin
          req_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      dpc4_q       <= 32'h0000_0000;
      inst_q       <= NOP_WORD;
      inst_valid_q <= 1'b0;
      req_q        <= 1'b0;
      hold_buf_q   <= 32'h0000_0000;
      redir_pc_q   <= 32'h0000_0000;
      redir_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      dpc4_q       <= dpc4_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      req_q        <= req_d;
      hold_buf_q   <= hold_buf_d;
      redir_pc_q   <= redir_pc_d;
      redir_pend_q <= redir_pend_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign dpc4       = dpc4_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_pipe_if_unit.sv
// Directed-vector bench for pipe_if_unit; memory returns {16'hC0DE, addr[15:0]}.
module tb_pipe_if_unit;
  logic        clock = 1'b0;
  logic        resetn;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        wpcir, jwait;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, dpc4, inst;
  logic        inst_valid;

  int vec_cnt = 0;
  int err_cnt = 0;

  pipe_if_unit dut (
    .clock(clock), .resetn(resetn), .pcsource(pcsource), .bpc(bpc), .da(da), .jpc(jpc),
    .wpcir(wpcir), .jwait(jwait), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack), .pc(pc), .dpc4(dpc4),
    .inst(inst), .inst_valid(inst_valid)
  );

  always #5 clock = ~clock;

  assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    resetn = 1'b0; pcsource = 2'b00; bpc = 32'h0; da = 32'h0; jpc = 32'h0;
    wpcir = 1'b1; jwait = 1'b0; imem_ack = 1'b0;
    step(); step();
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_dpc4", dpc4, 32'h0);

    resetn = 1'b1;
    #1;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, 32'h0);

    // Sequential fetch with zero-wait memory
    imem_ack = 1'b1;
    step();
    chk("seq_pc4", pc, 32'h4);
    chk("seq_inst0", inst, 32'hC0DE_0000);
    chk("seq_valid", {31'd0, inst_valid}, 32'd1);
    chk("seq_dpc4", dpc4, 32'h4);
    step();
    chk("seq_pc8", pc, 32'h8);
    chk("seq_inst4", inst, 32'hC0DE_0004);

    // Stall three cycles on the word at pc=8
    wpcir = 1'b0;
    step();
    chk("stall_pc", pc, 32'h8);
    chk("stall_req", {31'd0, imem_req}, 32'd0);
    chk("stall_inst", inst, 32'hC0DE_0004);
    imem_ack = 1'b0;
    step(); step();
    chk("stall3_pc", pc, 32'h8);
    chk("stall3_req", {31'd0, imem_req}, 32'd0);
    wpcir = 1'b1;
    step();
    chk("rel_inst", inst, 32'hC0DE_0008);
    chk("rel_pc", pc, 32'hC);
    chk("rel_dpc4", dpc4, 32'hC);
    chk("rel_req", {31'd0, imem_req}, 32'd1);

    // Taken branch with ack in the same cycle, wrong-path word squashed
    imem_ack = 1'b1; pcsource = 2'b01; bpc = 32'h40; jwait = 1'b1;
    step();
    chk("br_pc", pc, 32'h40);
    chk("br_inst", inst, 32'h0);
    chk("br_valid", {31'd0, inst_valid}, 32'd0);
    chk("br_dpc4", dpc4, 32'h10);

    // Slow memory: jr during the wait, then late ack
    pcsource = 2'b00; jwait = 1'b0; imem_ack = 1'b0;
    step();
    chk("slow_pc", pc, 32'h40);
    chk("slow_valid", {31'd0, inst_valid}, 32'd0);
    pcsource = 2'b10; da = 32'h100;
    step();
    chk("slow_pc_held", pc, 32'h40);
    chk("slow_addr", imem_addr, 32'h40);
    pcsource = 2'b00; imem_ack = 1'b1;
    step();
    chk("slow_redir_pc", pc, 32'h100);
    chk("slow_discard", inst, 32'h0);
    chk("slow_disc_valid", {31'd0, inst_valid}, 32'd0);
    step();
    chk("slow_after_pc", pc, 32'h104);
    chk("slow_after_inst", inst, 32'hC0DE_0100);

    // Wrap-around at the top of the address space
    pcsource = 2'b11; jpc = 32'hFFFF_FFFC; jwait = 1'b1;
    step();
    chk("wrap_jpc", pc, 32'hFFFF_FFFC);
    pcsource = 2'b00; jwait = 1'b0;
    step();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_dpc4", dpc4, 32'h0);
    chk("wrap_inst", inst, 32'hC0DE_FFFC);
    step();
    chk("wrap_pc4", pc, 32'h4);

    // Asynchronous reset with a request outstanding, then a late ack
    imem_ack = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    chk("arst_inst", inst, 32'h0);
    chk("arst_valid", {31'd0, inst_valid}, 32'd0);
    chk("arst_dpc4", dpc4, 32'h0);
    step();
    imem_ack = 1'b1;
    resetn = 1'b1;
    step();
    chk("late_ack_pc", pc, 32'h0);
    chk("late_ack_req", {31'd0, imem_req}, 32'd1);
    chk("late_ack_inst", inst, 32'h0);
    step();
    chk("refetch_pc", pc, 32'h4);
    chk("refetch_inst", inst, 32'hC0DE_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
